// File: rtl/stall_control.sv
// Pipeline hazard and stall controller for the LC-3b five-stage pipeline.
// Owns the RUN/DRAIN redirect FSM, the held redirect target and perf counters.
module stall_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_uses_sr1,
    input  logic        id_uses_sr2,
    input  logic [2:0]  id_src1,
    input  logic [2:0]  id_src2,
    input  logic        ex_load,
    input  logic        ex_regfile_write,
    input  logic [2:0]  ex_dest,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        dmem_resp,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        pc_load,
    output logic        if_id_load,
    output logic        id_ex_load,
    output logic        ex_mem_load,
    output logic        mem_wb_load,
    output logic        if_id_bubble,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mem_wb_bubble,
    output logic        pc_redirect_sel,
    output logic [15:0] pc_redirect_target,
    output logic        drain_active,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] target_q;
    logic [15:0] target_next;
    logic        stall_inc;
    logic        flush_inc;

    logic dmem_busy;
    logic imem_busy;
    logic src1_hit;
    logic src2_hit;
    logic load_use;

    assign dmem_busy = (dmem_read | dmem_write) & ~dmem_resp;
    assign imem_busy = imem_read & ~imem_resp;
    assign src1_hit  = id_uses_sr1 & (id_src1 == ex_dest);
    assign src2_hit  = id_uses_sr2 & (id_src2 == ex_dest);
    assign load_use  = ex_load & ex_regfile_write & (src1_hit | src2_hit);

    always_comb begin
        pc_load            = 1'b1;
        if_id_load         = 1'b1;
        id_ex_load         = 1'b1;
        ex_mem_load        = 1'b1;
        mem_wb_load        = 1'b1;
        if_id_bubble       = 1'b0;
        id_ex_bubble       = 1'b0;
        ex_mem_bubble      = 1'b0;
        mem_wb_bubble      = 1'b0;
        pc_redirect_sel    = 1'b0;
        pc_redirect_target = branch_target;
        drain_active       = (state == DRAIN);
        state_next         = state;
        target_next        = target_q;
        stall_inc          = 1'b0;
        flush_inc          = 1'b0;

        if (reset) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
            drain_active = 1'b0;
            state_next   = RUN;
            target_next  = 16'h0000;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_busy) begin
                        pc_load       = 1'b0;
                        if_id_load    = 1'b0;
                        id_ex_load    = 1'b0;
                        ex_mem_load   = 1'b0;
                        mem_wb_bubble = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (branch_taken) begin
                        if_id_bubble  = 1'b1;
                        id_ex_bubble  = 1'b1;
                        ex_mem_bubble = 1'b1;
                        flush_inc     = 1'b1;
                        if (!imem_busy) begin
                            pc_redirect_sel = 1'b1;
                        end else begin
                            // fetch in flight: hold target until it lands
                            pc_load     = 1'b0;
                            target_next = branch_target;
                            state_next  = DRAIN;
                        end
                    end else if (load_use) begin
                        pc_load      = 1'b0;
                        if_id_load   = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end else if (imem_busy) begin
                        pc_load      = 1'b0;
                        if_id_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_redirect_target = target_q;
                    pc_load            = 1'b0;
                    if_id_bubble       = 1'b1;
                    stall_inc          = 1'b1;
                    if (dmem_busy) begin
                        if_id_load    = 1'b0;
                        id_ex_load    = 1'b0;
                        ex_mem_load   = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else if (imem_resp) begin
                        // stale fetch word is discarded via if_id_bubble
                        pc_load         = 1'b1;
                        pc_redirect_sel = 1'b1;
                        state_next      = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            target_q    <= 16'h0000;
            stall_count <= 16'h0000;
            flush_count <= 16'h0000;
        end else begin
            state    <= state_next;
            target_q <= target_next;
            if (stall_inc && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'h0001;
            if (flush_inc && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_stall_control.sv
// Directed self-checking bench for stall_control.
// Inputs change 1ns after rising edges; outputs sampled mid-cycle.
module tb_stall_control;

    logic        clk;
    logic        reset;
    logic        id_uses_sr1, id_uses_sr2;
    logic [2:0]  id_src1, id_src2;
    logic        ex_load, ex_regfile_write;
    logic [2:0]  ex_dest;
    logic        imem_read, imem_resp;
    logic        dmem_read, dmem_write, dmem_resp;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic        pc_redirect_sel;
    logic [15:0] pc_redirect_target;
    logic        drain_active;
    logic [15:0] stall_count, flush_count;

    logic [4:0] loads;
    logic [3:0] bubs;
    int         errors;
    int         checks;

    assign loads = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    assign bubs  = {if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble};

    stall_control dut (
        .clk(clk),
        .reset(reset),
        .id_uses_sr1(id_uses_sr1),
        .id_uses_sr2(id_uses_sr2),
        .id_src1(id_src1),
        .id_src2(id_src2),
        .ex_load(ex_load),
        .ex_regfile_write(ex_regfile_write),
        .ex_dest(ex_dest),
        .imem_read(imem_read),
        .imem_resp(imem_resp),
        .dmem_read(dmem_read),
        .dmem_write(dmem_write),
        .dmem_resp(dmem_resp),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc_load(pc_load),
        .if_id_load(if_id_load),
        .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load),
        .mem_wb_load(mem_wb_load),
        .if_id_bubble(if_id_bubble),
        .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_bubble(mem_wb_bubble),
        .pc_redirect_sel(pc_redirect_sel),
        .pc_redirect_target(pc_redirect_target),
        .drain_active(drain_active),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_uses_sr1      = 1'b0;
        id_uses_sr2      = 1'b0;
        id_src1          = 3'd0;
        id_src2          = 3'd0;
        ex_load          = 1'b0;
        ex_regfile_write = 1'b0;
        ex_dest          = 3'd0;
        imem_read        = 1'b0;
        imem_resp        = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_resp        = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = 16'h0000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_loads", loads, 5'b00000);
        chk("rst_bubs", bubs, 4'b0000);
        chk("rst_sel", pc_redirect_sel, 1'b0);
        chk("rst_drain", drain_active, 1'b0);
        tick();
        tick();
        chk("rst_stall", stall_count, 16'd0);
        chk("rst_flush", flush_count, 16'd0);
        reset = 1'b0;

        // idle
        branch_target = 16'hABCD;
        #1;
        chk("idle_loads", loads, 5'b11111);
        chk("idle_bubs", bubs, 4'b0000);
        chk("idle_tgt", pc_redirect_target, 16'hABCD);
        tick();
        chk("idle_stall", stall_count, 16'd0);

        // load-use on SR1
        idle_inputs();
        ex_load = 1'b1; ex_regfile_write = 1'b1; ex_dest = 3'd3;
        id_uses_sr1 = 1'b1; id_src1 = 3'd3;
        #1;
        chk("lu1_loads", loads, 5'b00111);
        chk("lu1_bubs", bubs, 4'b0100);
        tick();
        chk("lu1_stall", stall_count, 16'd1);

        // no hazard: mismatched source, then non-writing load
        id_src1 = 3'd4;
        #1;
        chk("lu_miss_loads", loads, 5'b11111);
        id_src1 = 3'd3; ex_regfile_write = 1'b0;
        #1;
        chk("lu_nowr_loads", loads, 5'b11111);
        tick();
        chk("lu_miss_stall", stall_count, 16'd1);

        // load-use on SR2
        idle_inputs();
        ex_load = 1'b1; ex_regfile_write = 1'b1; ex_dest = 3'd6;
        id_uses_sr2 = 1'b1; id_src2 = 3'd6; id_src1 = 3'd6;
        #1;
        chk("lu2_bubs", bubs, 4'b0100);
        tick();
        chk("lu2_stall", stall_count, 16'd2);

        // dmem read busy 3 cycles then resp
        idle_inputs();
        dmem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dm_loads", loads, 5'b00001);
            chk("dm_bubs", bubs, 4'b0001);
            tick();
        end
        chk("dm_stall", stall_count, 16'd5);
        dmem_resp = 1'b1;
        #1;
        chk("dm_resp_loads", loads, 5'b11111);
        chk("dm_resp_bubs", bubs, 4'b0000);
        tick();
        chk("dm_resp_stall", stall_count, 16'd5);

        // branch during dmem busy is ignored, taken on resp
        idle_inputs();
        dmem_write = 1'b1; branch_taken = 1'b1; branch_target = 16'h2222;
        #1;
        chk("dmbr_loads", loads, 5'b00001);
        chk("dmbr_sel", pc_redirect_sel, 1'b0);
        tick();
        chk("dmbr_flush", flush_count, 16'd0);
        dmem_resp = 1'b1;
        #1;
        chk("dmbr_resp_loads", loads, 5'b11111);
        chk("dmbr_resp_bubs", bubs, 4'b1110);
        chk("dmbr_resp_sel", pc_redirect_sel, 1'b1);
        chk("dmbr_resp_tgt", pc_redirect_target, 16'h2222);
        tick();
        chk("dmbr_flush2", flush_count, 16'd1);
        chk("dmbr_stall", stall_count, 16'd6);

        // branch with imem idle
        idle_inputs();
        branch_taken = 1'b1; branch_target = 16'h1234;
        #1;
        chk("br_loads", loads, 5'b11111);
        chk("br_bubs", bubs, 4'b1110);
        chk("br_sel", pc_redirect_sel, 1'b1);
        chk("br_tgt", pc_redirect_target, 16'h1234);
        tick();
        chk("br_flush", flush_count, 16'd2);
        chk("br_drain", drain_active, 1'b0);

        // imem busy alone
        idle_inputs();
        imem_read = 1'b1;
        #1;
        chk("im_loads", loads, 5'b01111);
        chk("im_bubs", bubs, 4'b1000);
        tick();
        chk("im_stall", stall_count, 16'd7);

        // branch with fetch in flight -> DRAIN
        idle_inputs();
        imem_read = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        #1;
        chk("bd_loads", loads, 5'b01111);
        chk("bd_bubs", bubs, 4'b1110);
        chk("bd_sel", pc_redirect_sel, 1'b0);
        tick();
        chk("bd_drain", drain_active, 1'b1);
        chk("bd_flush", flush_count, 16'd3);
        chk("bd_stall", stall_count, 16'd7);
        branch_taken = 1'b0; branch_target = 16'hFFFF;
        ex_load = 1'b1; ex_regfile_write = 1'b1; ex_dest = 3'd2;
        id_uses_sr1 = 1'b1; id_src1 = 3'd2;
        #1;
        chk("dr1_loads", loads, 5'b01111);
        chk("dr1_bubs", bubs, 4'b1000);
        chk("dr1_tgt", pc_redirect_target, 16'h0040);
        tick();
        chk("dr1_drain", drain_active, 1'b1);
        chk("dr1_stall", stall_count, 16'd8);
        imem_resp = 1'b1;
        #1;
        chk("dr2_loads", loads, 5'b11111);
        chk("dr2_bubs", bubs, 4'b1000);
        chk("dr2_sel", pc_redirect_sel, 1'b1);
        chk("dr2_tgt", pc_redirect_target, 16'h0040);
        chk("dr2_drain", drain_active, 1'b1);
        tick();
        chk("dr2_run", drain_active, 1'b0);
        chk("dr2_stall", stall_count, 16'd9);

        // DRAIN with dmem busy holds, then reset mid-DRAIN
        idle_inputs();
        imem_read = 1'b1; branch_taken = 1'b1; branch_target = 16'h0777;
        tick();
        chk("dd_flush", flush_count, 16'd4);
        branch_taken = 1'b0; imem_resp = 1'b1; dmem_read = 1'b1;
        #1;
        chk("dd_loads", loads, 5'b00001);
        chk("dd_bubs", bubs, 4'b1001);
        tick();
        chk("dd_drain", drain_active, 1'b1);
        chk("dd_stall", stall_count, 16'd10);
        reset = 1'b1;
        #1;
        chk("rd_loads", loads, 5'b00000);
        chk("rd_bubs", bubs, 4'b0000);
        chk("rd_drain", drain_active, 1'b0);
        tick();
        reset = 1'b0;
        idle_inputs();
        branch_target = 16'h5A5A;
        #1;
        chk("rd_run", drain_active, 1'b0);
        chk("rd_stall", stall_count, 16'd0);
        chk("rd_flush", flush_count, 16'd0);
        chk("rd_tgt", pc_redirect_target, 16'h5A5A);
        chk("rd_idle_loads", loads, 5'b11111);

        // saturation
        imem_read = 1'b1;
        repeat (70000) tick();
        chk("sat_stall", stall_count, 16'hFFFF);
        chk("sat_flush", flush_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stall_control.md
STALL_CONTROL -- requirements
Module: stall_control

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: id_uses_sr1, id_uses_sr2  input  1 each  instruction in ID reads SR1/SR2.
REQ-004 SHALL: id_src1, id_src2  input  lc3b_reg (3)  ID source registers.
REQ-005 SHALL: ex_load, ex_regfile_write  input  1 each  instruction in EX is a load / writes regfile.
REQ-006 SHALL: ex_dest  input  lc3b_reg (3)  EX destination register.
REQ-007 SHALL: imem_read, imem_resp  input  1 each  fetch request / fetch completion.
REQ-008 SHALL: dmem_read, dmem_write, dmem_resp  input  1 each  MEM-stage access / completion.
REQ-009 SHALL: branch_taken  input  1  MEM-stage redirect; branch_target  input  16  redirect address.
REQ-010 SHALL: pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  output  1 each  register enables.
REQ-011 SHALL: if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  output  1 each  load a NOP instead of upstream data.
REQ-012 SHALL: pc_redirect_sel  output  1  PC mux selects pc_redirect_target; pc_redirect_target  output  16.
REQ-013 SHALL: drain_active  output  1  FSM in DRAIN; stall_count, flush_count  output  16 each  perf counters.

Function
REQ-014 SHALL: FSM states RUN, DRAIN; held 16-bit target register; counters are registers; all other outputs combinational from state and inputs.
REQ-015 SHALL: dmem_busy = (dmem_read|dmem_write) & !dmem_resp; imem_busy = imem_read & !imem_resp; load_use = ex_load & ex_regfile_write & ((id_uses_sr1 & id_src1==ex_dest) | (id_uses_sr2 & id_src2==ex_dest)).
REQ-016 SHALL: defaults: all *_load=1, all bubbles=0, pc_redirect_sel=0, pc_redirect_target=branch_target.
REQ-017 SHALL: RUN, priority 1, dmem_busy: pc_load, if_id_load, id_ex_load, ex_mem_load=0; mem_wb_load=1, mem_wb_bubble=1; branch_taken ignored; stall_count+1.
REQ-018 SHALL: RUN, priority 2, branch_taken: if_id_bubble, id_ex_bubble, ex_mem_bubble=1; flush_count+1; if !imem_busy then pc_load=1, pc_redirect_sel=1, stay RUN; else pc_load=0, latch branch_target, go DRAIN.
REQ-019 SHALL: RUN, priority 3, load_use: pc_load=0, if_id_load=0, id_ex_bubble=1; stall_count+1; single-cycle stall per occurrence.
REQ-020 SHALL: RUN, priority 4, imem_busy: pc_load=0, if_id_bubble=1; stall_count+1.
REQ-021 SHALL: DRAIN: pc_load=0, if_id_bubble=1 every cycle; load_use and branch_taken not evaluated; stall_count+1 each cycle.
REQ-022 SHALL: DRAIN with dmem_busy: REQ-017 enables/bubbles apply, pc_load=0, remain DRAIN.
REQ-023 SHALL: DRAIN with imem_resp=1: pc_load=1, pc_redirect_sel=1, pc_redirect_target=latched target, if_id_bubble=1 (fetched word discarded), go RUN next cycle.
REQ-024 SHALL: pc_redirect_target outputs latched target whenever state is DRAIN.
REQ-025 SHALL: counters saturate at 0xFFFF; at most +1 per cycle each.

Reset
REQ-026 SHALL: reset high at an edge: state=RUN, target=0x0000, stall_count=0, flush_count=0, overriding any pending DRAIN.
REQ-027 SHALL: while reset high: all *_load=0, all bubbles=0, pc_redirect_sel=0, drain_active=0.

Verification
REQ-028 SHALL: ex_load=1, ex_regfile_write=1, ex_dest=3, id_uses_sr1=1, id_src1=3 for one cycle -> pc_load=0, if_id_load=0, id_ex_bubble=1, stall_count 0->1.
REQ-029 SHALL: dmem_read=1, dmem_resp=0 for 3 cycles then 1 -> 3 cycles of front/mid loads=0, mem_wb_bubble=1; resp cycle all loads=1; stall_count=3.
REQ-030 SHALL: branch_taken=1, branch_target=0x1234, imem idle -> pc_load=1, pc_redirect_sel=1, target 0x1234, three bubbles, flush_count=1, state RUN.
REQ-031 SHALL: branch_taken=1, target=0x0040, imem_read=1, imem_resp=0; imem_resp after 2 more cycles -> DRAIN 2 cycles with drain_active=1, resp cycle pc_redirect_target=0x0040, pc_load=1, if_id_bubble=1, then RUN.
REQ-032 SHALL: dmem_busy and branch_taken together -> branch ignored, flush_count unchanged; branch acted on in dmem_resp cycle.
REQ-033 SHALL: reset asserted mid-DRAIN -> next cycle state RUN, drain_active=0, counters 0; 70000 stall cycles -> stall_count=0xFFFF.
